// File: rtl/router_pkg.sv
// Shared definitions for the router receive path: header field layout,
// decapsulator state encoding and the packet-number wrap rule.
package router_pkg;

    // Header layout of a 64-bit Aurora word: {payload, dst, ttl, num, src}
    localparam int TTL_LSB   = 7;
    localparam int TTL_WIDTH = 2;
    localparam int NUM_LSB   = 2;
    localparam int NUM_WIDTH = 5;
    localparam int SRC_LSB   = 0;
    localparam int HDR_WIDTH = 9;
    localparam int DST_LSB   = HDR_WIDTH;

    localparam int DEFAULT_PAYLOAD_WIDTH = 64 - HDR_WIDTH - 10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        CHECK,
        PRESENT,
        WRITE
    } decap_state_t;

    function automatic int payload_width(input int data_width, input int addr_width);
        return data_width - HDR_WIDTH - addr_width;
    endfunction

    // Packet number 0 only ever opens a stream; after the top number it wraps to 1.
    function automatic logic [NUM_WIDTH-1:0] next_pkt_num(
        input logic [NUM_WIDTH-1:0] n,
        input logic [NUM_WIDTH-1:0] max_num
    );
        return (n == max_num) ? NUM_WIDTH'(1) : n + NUM_WIDTH'(1);
    endfunction

endpackage

// File: rtl/dfx_seq_tracker.sv
// Per-source expected packet-number table for the local delivery path.
// Flags a sequence error when a synced source skips or repeats a number.
module dfx_seq_tracker
    import router_pkg::*;
#(
    parameter int RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int NUMBER_PACKET          = 19
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              update,
    input  logic [RECOGNIZE_ROUTER_WIDTH-1:0] src,
    input  logic [NUM_WIDTH-1:0]              num,
    output logic                              seq_err
);

    localparam int                   ENTRIES = 1 << RECOGNIZE_ROUTER_WIDTH;
    localparam logic [NUM_WIDTH-1:0] MAX_NUM = NUMBER_PACKET[NUM_WIDTH-1:0];

    logic [ENTRIES-1:0]   synced;
    logic [NUM_WIDTH-1:0] expected [ENTRIES];

    assign seq_err = update && synced[src] && (num != expected[src]);

    // NOTE: only the synced bits are reset; an expected entry is never read
    // until its synced bit is set, so the table itself needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            synced <= '0;
        end else if (update) begin
            // First packet, in-order packet and mismatch all resync to the received number.
            synced[src]   <= 1'b1;
            expected[src] <= next_pkt_num(num, MAX_NUM);
        end
    end

endmodule

// File: rtl/dfx_pkt_decap.sv
// Receive-side decapsulator for router output port 0 (local delivery).
// Optional per-source sequence checking is enabled by DFX_DECAP_SEQ_CHECK_EN.
module dfx_pkt_decap
    import router_pkg::*;
#(
    parameter int                              AURORA_DATA_WIDTH      = 64,
    parameter int                              ADDR_WIDTH             = 10,
    parameter int                              NUMBER_PACKET          = 19,
    parameter int                              RECOGNIZE_ROUTER_WIDTH = 2,
    parameter logic [RECOGNIZE_ROUTER_WIDTH-1:0] LOCAL_ROUTER_ID      = 2'b00,
    localparam int                             PAYLOAD_WIDTH          = payload_width(AURORA_DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         empty_output_port_0,
    input  logic [AURORA_DATA_WIDTH-1:0] dout_output_port_0,
    output logic                         fifo_rd,
    output logic                         valid_dfx_data,
    output logic [ADDR_WIDTH-1:0]        dst_addr_arbiter_recv,
    input  logic                         rd_output_port_0,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [PAYLOAD_WIDTH-1:0]     mem_wdata,
    output logic [15:0]                  drop_cnt,
    output logic [15:0]                  seq_err_cnt
);

    localparam logic [NUM_WIDTH-1:0] MAX_NUM = NUMBER_PACKET[NUM_WIDTH-1:0];
    localparam int                   PL_LSB  = DST_LSB + ADDR_WIDTH;

    decap_state_t state, state_next;

    logic [AURORA_DATA_WIDTH-1:0]      hold;
    logic [TTL_WIDTH-1:0]              ttl;
    logic [NUM_WIDTH-1:0]              num;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0]             dst;
    logic [PAYLOAD_WIDTH-1:0]          payload;
    logic                              drop;

    assign ttl     = hold[TTL_LSB +: TTL_WIDTH];
    assign num     = hold[NUM_LSB +: NUM_WIDTH];
    assign src     = hold[SRC_LSB +: RECOGNIZE_ROUTER_WIDTH];
    assign dst     = hold[DST_LSB +: ADDR_WIDTH];
    assign payload = hold[PL_LSB +: PAYLOAD_WIDTH];

    // Any one condition drops the word; listed in the order they are judged.
    assign drop = (ttl != '0) || (src == LOCAL_ROUTER_ID) || (num > MAX_NUM);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next            = state;
        fifo_rd               = 1'b0;
        valid_dfx_data        = 1'b0;
        dst_addr_arbiter_recv = '0;
        mem_we                = 1'b0;
        mem_addr              = '0;
        mem_wdata             = '0;
        case (state)
            IDLE: begin
                if (!empty_output_port_0) state_next = FETCH;
            end
            FETCH: begin
                fifo_rd    = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                state_next = CHECK;
            end
            CHECK: begin
                state_next = drop ? IDLE : PRESENT;
            end
            PRESENT: begin
                valid_dfx_data        = 1'b1;
                dst_addr_arbiter_recv = dst;
                if (rd_output_port_0) state_next = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                mem_addr   = dst;
                mem_wdata  = payload;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The FIFO presents data one cycle after the pop, i.e. during LOAD.
    always_ff @(posedge clk) begin
        if (rst)                hold <= '0;
        else if (state == LOAD) hold <= dout_output_port_0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if ((state == CHECK) && drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef DFX_DECAP_SEQ_CHECK_EN
    logic seq_update;
    logic seq_err;

    assign seq_update = (state == CHECK) && !drop;

    dfx_seq_tracker #(
        .RECOGNIZE_ROUTER_WIDTH (RECOGNIZE_ROUTER_WIDTH),
        .NUMBER_PACKET          (NUMBER_PACKET)
    ) u_seq_tracker (
        .clk     (clk),
        .rst     (rst),
        .update  (seq_update),
        .src     (src),
        .num     (num),
        .seq_err (seq_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_err_cnt <= '0;
        end else if (seq_err && (seq_err_cnt != 16'hFFFF)) begin
            seq_err_cnt <= seq_err_cnt + 16'd1;
        end
    end
`else
    assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_dfx_pkt_decap.sv
// Directed self-checking bench for dfx_pkt_decap: acceptance, drops,
// sequence tracking, cycle timing and mid-packet reset.
module tb_dfx_pkt_decap;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        empty_output_port_0 = 1'b1;
    logic [63:0] dout_output_port_0 = '0;
    logic        fifo_rd;
    logic        valid_dfx_data;
    logic [9:0]  dst_addr_arbiter_recv;
    logic        rd_output_port_0 = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [44:0] mem_wdata;
    logic [15:0] drop_cnt;
    logic [15:0] seq_err_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit valid_seen = 1'b0;

    logic [63:0] fifo_q [$];
    int          rd_cycles [$];
    logic [9:0]  we_addr [$];
    logic [44:0] we_data [$];

`ifdef DFX_DECAP_SEQ_CHECK_EN
    localparam logic [15:0] EXP_SEQ_ERR = 16'd1;
`else
    localparam logic [15:0] EXP_SEQ_ERR = 16'd0;
`endif

    dfx_pkt_decap dut (
        .clk                   (clk),
        .rst                   (rst),
        .empty_output_port_0   (empty_output_port_0),
        .dout_output_port_0    (dout_output_port_0),
        .fifo_rd               (fifo_rd),
        .valid_dfx_data        (valid_dfx_data),
        .dst_addr_arbiter_recv (dst_addr_arbiter_recv),
        .rd_output_port_0      (rd_output_port_0),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .drop_cnt              (drop_cnt),
        .seq_err_cnt           (seq_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] ttl, input logic [4:0] num,
                                       input logic [1:0] src, input logic [9:0] dst,
                                       input logic [44:0] pl);
        return {pl, dst, ttl, num, src};
    endfunction

    // One cycle: advance to the falling edge, then act as the FIFO and log outputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (fifo_rd) begin
            rd_cycles.push_back(cyc);
            if (fifo_q.size() > 0) dout_output_port_0 = fifo_q.pop_front();
        end
        if (mem_we) begin
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
        end
        if (valid_dfx_data) valid_seen = 1'b1;
        empty_output_port_0 = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [63:0] w);
        fifo_q.push_back(w);
        empty_output_port_0 = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!valid_dfx_data && n < max_cycles) begin
            step();
            n++;
        end
        if (!valid_dfx_data) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int we_base;

        // Reset state
        repeat (3) step();
        check("rst_outputs", {fifo_rd, valid_dfx_data, dst_addr_arbiter_recv, mem_we,
                              mem_addr, mem_wdata}, 64'd0);
        check("rst_counters", {drop_cnt, seq_err_cnt}, 64'd0);
        rst = 1'b0;
        step();

        // Good packet from source 10, grant held back three cycles
        push(mk(2'b00, 5'd1, 2'b10, 10'h05A, 45'h0123_4567_89AB));
        wait_valid("t1_valid", 20);
        check("t1_dst", dst_addr_arbiter_recv, 64'h05A);
        repeat (3) step();
        check("t1_hold_valid", valid_dfx_data, 64'd1);
        check("t1_hold_dst", dst_addr_arbiter_recv, 64'h05A);
        check("t1_no_early_we", we_addr.size(), 64'd0);
        rd_output_port_0 = 1'b1;
        step();
        rd_output_port_0 = 1'b0;
        check("t1_we", mem_we, 64'd1);
        check("t1_addr", mem_addr, 64'h05A);
        check("t1_data", mem_wdata, 64'h0123_4567_89AB);
        check("t1_dst_zero_in_write", dst_addr_arbiter_recv, 64'd0);
        step();
        check("t1_idle_outs", {valid_dfx_data, mem_we}, 64'd0);
        check("t1_we_count", we_addr.size(), 64'd1);
        check("t1_counters", {drop_cnt, seq_err_cnt}, 64'd0);

        // TTL nonzero and local source, back to back: both dropped, 4 cycles each
        rd_cycles.delete();
        valid_seen = 1'b0;
        push(mk(2'b01, 5'd2, 2'b10, 10'h100, 45'h1));
        push(mk(2'b00, 5'd3, 2'b00, 10'h101, 45'h2));
        repeat (12) step();
        check("t2_pops", rd_cycles.size(), 64'd2);
        if (rd_cycles.size() == 2) check("t2_drop_gap", rd_cycles[1] - rd_cycles[0], 64'd4);
        check("t2_drop_cnt", drop_cnt, 64'd2);
        check("t2_no_valid", valid_seen, 64'd0);
        check("t2_no_we", we_addr.size(), 64'd1);

        // Packet number 20 is out of range
        push(mk(2'b00, 5'd20, 2'b11, 10'h102, 45'h3));
        repeat (8) step();
        check("t3_drop_cnt", drop_cnt, 64'd3);
        check("t3_no_valid", valid_seen, 64'd0);
        check("t3_no_we", we_addr.size(), 64'd1);

        // Source 01: 18, 19, 1 with grant held high throughout (zero-wait)
        rd_cycles.delete();
        we_addr.delete();
        we_data.delete();
        rd_output_port_0 = 1'b1;
        push(mk(2'b00, 5'd18, 2'b01, 10'h011, 45'h11));
        push(mk(2'b00, 5'd19, 2'b01, 10'h012, 45'h12));
        push(mk(2'b00, 5'd1,  2'b01, 10'h013, 45'h13));
        repeat (24) step();
        rd_output_port_0 = 1'b0;
        check("t4_we_count", we_addr.size(), 64'd3);
        if (we_addr.size() == 3) begin
            check("t4_addr0", we_addr[0], 64'h011);
            check("t4_addr1", we_addr[1], 64'h012);
            check("t4_addr2", we_addr[2], 64'h013);
            check("t4_data2", we_data[2], 64'h13);
        end
        check("t4_pops", rd_cycles.size(), 64'd3);
        if (rd_cycles.size() == 3) begin
            check("t4_gap0", rd_cycles[1] - rd_cycles[0], 64'd6);
            check("t4_gap1", rd_cycles[2] - rd_cycles[1], 64'd6);
        end
        check("t4_seq_err", seq_err_cnt, 64'd0);

        // Source 01 skips to 3: sequence error, still delivered
        rd_output_port_0 = 1'b1;
        push(mk(2'b00, 5'd3, 2'b01, 10'h020, 45'h1F_FFFF_FFFF));
        repeat (8) step();
        rd_output_port_0 = 1'b0;
        check("t5_we_count", we_addr.size(), 64'd4);
        if (we_addr.size() == 4) begin
            check("t5_addr", we_addr[3], 64'h020);
            check("t5_data", we_data[3], 64'h1F_FFFF_FFFF);
        end
        check("t5_seq_err", seq_err_cnt, EXP_SEQ_ERR);
        check("t5_drop_cnt", drop_cnt, 64'd3);

        // Reset while presenting, with a grant arriving in the same cycle
        push(mk(2'b00, 5'd7, 2'b11, 10'h155, 45'h55));
        wait_valid("t6_valid", 20);
        check("t6_dst", dst_addr_arbiter_recv, 64'h155);
        we_base = we_addr.size();
        rst = 1'b1;
        rd_output_port_0 = 1'b1;
        step();
        check("t6_rst_outs", {valid_dfx_data, mem_we, dst_addr_arbiter_recv}, 64'd0);
        check("t6_rst_counters", {drop_cnt, seq_err_cnt}, 64'd0);
        rst = 1'b0;
        rd_output_port_0 = 1'b0;
        valid_seen = 1'b0;
        repeat (6) step();
        check("t6_no_we", we_addr.size(), we_base);
        check("t6_no_valid", valid_seen, 64'd0);

        // Next word after reset: source 01 is unsynced again, so 5 is clean
        push(mk(2'b00, 5'd5, 2'b01, 10'h2AA, 45'h0AAA_5555_0F0F));
        wait_valid("t7_valid", 20);
        check("t7_dst", dst_addr_arbiter_recv, 64'h2AA);
        rd_output_port_0 = 1'b1;
        step();
        rd_output_port_0 = 1'b0;
        check("t7_we", mem_we, 64'd1);
        check("t7_addr", mem_addr, 64'h2AA);
        check("t7_data", mem_wdata, 64'h0AAA_5555_0F0F);
        step();
        check("t7_seq_err", seq_err_cnt, 64'd0);
        check("t7_we_count", we_addr.size(), we_base + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time got=expired exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dfx_pkt_decap.md
# dfx_pkt_decap

Receive-side decapsulator on router output port 0, the local delivery path. It pops 64-bit Aurora words from the output-port-0 FIFO and validates the 9-bit header {TTL, packet number, source router} produced by the transmit encapsulation. It offers each good packet to the router controller as `valid_dfx_data` plus `dst_addr_arbiter_recv`, then writes the payload into DFX memory once the controller grants. It drops echoes and malformed words, and tracks per-source sequence numbers.

## Interface
- `AURORA_DATA_WIDTH`, 64: FIFO word width.
- `ADDR_WIDTH`, 10: DFX memory address width.
- `NUMBER_PACKET`, 19: highest packet number before wrap.
- `RECOGNIZE_ROUTER_WIDTH`, 2: source-router ID width.
- `LOCAL_ROUTER_ID`, 2'b00: this router's ID.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `empty_output_port_0` in 1: FIFO empty.
- `dout_output_port_0` in AURORA_DATA_WIDTH: FIFO read data. Valid one cycle after `fifo_rd`.
- `fifo_rd` out 1: FIFO pop strobe.
- `valid_dfx_data` out 1: packet held and ready for arbitration.
- `dst_addr_arbiter_recv` out ADDR_WIDTH: destination address of the held packet.
- `rd_output_port_0` in 1: controller grant pulse. Consumes the held packet.
- `mem_we` out 1: DFX memory write strobe.
- `mem_addr` out ADDR_WIDTH: write address.
- `mem_wdata` out PAYLOAD_WIDTH: write data.
- `drop_cnt` out 16: dropped-word count. Saturating.
- `seq_err_cnt` out 16: sequence-error count. Saturating.

## Operation
- Word layout:
  - [8:7] TTL
  - [6:2] packet number
  - [1:0] source ID
  - [9+ADDR_WIDTH-1:9] destination address
  - upper bits are payload; PAYLOAD_WIDTH = AURORA_DATA_WIDTH-9-ADDR_WIDTH (45 at defaults)
- FSM states: IDLE, FETCH, LOAD, CHECK, PRESENT, WRITE.
  - IDLE → FETCH when `!empty_output_port_0`.
  - FETCH: `fifo_rd`=1 for one cycle → LOAD.
  - LOAD: capture `dout_output_port_0` into the holding register → CHECK.
  - CHECK: any drop condition → increment `drop_cnt` → IDLE. Otherwise → PRESENT.
  - PRESENT: `valid_dfx_data`=1 and `dst_addr_arbiter_recv`=field. Hold until `rd_output_port_0`=1 → WRITE.
  - WRITE: `mem_we`=1, `mem_addr`=dst field, `mem_wdata`=payload for one cycle → IDLE.
- Drop conditions, in priority order:
  - TTL≠0. The controller zeroes TTL on local delivery, so a nonzero TTL is malformed.
  - source ID == LOCAL_ROUTER_ID (own packet returned around the ring).
  - packet number > NUMBER_PACKET.
- Legal packet numbers are 0..NUMBER_PACKET.
  - Successor of n is n+1; successor of NUMBER_PACKET is 1.
  - 0 is only legal as the first packet after source reset.
- Counters saturate at 16'hFFFF; they never wrap.
- A dropped word is never presented and never written.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; all sequence entries "unsynced".
- Minimum 6 cycles per accepted packet (IDLE→WRITE, zero-wait grant); 4 cycles per dropped word.
- `fifo_rd` is never asserted outside FETCH. It is never asserted while `empty_output_port_0`=1 at the IDLE decision.
- `rd_output_port_0` is ignored outside PRESENT.
- `dst_addr_arbiter_recv` is stable throughout PRESENT and is 0 in all other states.
- A grant in the first PRESENT cycle is honoured; WRITE follows on the next cycle.
- Reset mid-operation returns to IDLE next cycle. The popped word is lost and no `mem_we` is issued.

## Configuration
- `DFX_DECAP_SEQ_CHECK_EN` defined:
  - Per-source expected-number table (2^RECOGNIZE_ROUTER_WIDTH entries plus a synced bit) is updated in CHECK.
  - A mismatch increments `seq_err_cnt` and resyncs the entry to the received number. The packet is still delivered.
  - The first packet from an unsynced source sets sync without error.
- `DFX_DECAP_SEQ_CHECK_EN` undefined: no table; `seq_err_cnt` is tied to 0. Range checking of the packet number stays active.

## Structure
- Package `router_pkg` holds:
  - header field offsets and widths, and PAYLOAD_WIDTH derivation
  - state enum `decap_state_t`
  - function `next_pkt_num(n)` implementing the wrap rule
- One sub-module, `dfx_seq_tracker`: the per-source expected-number table and error detect. It is instantiated only under the macro.

## Test plan
- Word TTL=0, num=1, src=01, dst=10'h05A, payload=X → `valid_dfx_data` with `dst_addr_arbiter_recv`=05A. Grant after 3 cycles → single `mem_we` at addr 05A with payload X; counters 0.
- Word TTL=2'b01 → no `valid_dfx_data`; `drop_cnt`=1; FSM back to IDLE after 4 cycles.
- Word src=00 (local) → dropped; `drop_cnt` increments; no `mem_we`.
- Source 01 sends numbers 18, 19, 1 → `seq_err_cnt`=0. Then 3 → `seq_err_cnt`=1 and packet still written. With the macro undefined, `seq_err_cnt` stays 0.
- Packet number 20 → dropped as out of range.
- Assert `rst` during PRESENT → next cycle `valid_dfx_data`=0, no `mem_we`, state IDLE. A following FIFO word is processed normally.
